// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles every control-path signal between the multi-cycle RV32I control
// FSM and its datapath/memory. Clock and reset are not part of the bundle.
//
//   master (controller side):
//     in : opcode[6:0], branch_taken, mem_ready
//     out: mem_req, mem_we, iord, ir_we, pc_we, pc_src[1:0], alu_src_a[1:0],
//          alu_src_b, alu_op[1:0], reg_we, wb_sel[1:0], illegal, retire,
//          instret[COUNT_W-1:0], state_o[3:0]
//   slave (datapath side): the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int COUNT_W = 32
);
    logic [6:0]         opcode;
    logic               branch_taken;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               ir_we;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic [1:0]         alu_src_a;
    logic               alu_src_b;
    logic [1:0]         alu_op;
    logic               reg_we;
    logic [1:0]         wb_sel;
    logic               illegal;
    logic               retire;
    logic [COUNT_W-1:0] instret;
    logic [3:0]         state_o;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_we, wb_sel, illegal, retire,
               instret, state_o
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_we, wb_sel, illegal, retire,
               instret, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for the multi-cycle RV32I datapath. Sequences the shared
// memory port, IR load, PC update, ALU operand muxes and register write-back
// for each instruction, and counts retired instructions.
//
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : multicycle_ctrl_if.master (opcode/branch_taken/mem_ready in,
//          all control strobes, instret and state_o out)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC     = 4'd2,
        ALU_WB   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_ACC  = 4'd5,
        LOAD_WB  = 4'd6,
        BRANCH   = 4'd7,
        JUMP     = 4'd8
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    state_t             r_state;
    logic [COUNT_W-1:0] r_instret;

    state_t     w_nextState;
    logic       w_memReq, w_memWe, w_iord, w_irWe, w_pcWe;
    logic [1:0] w_pcSrc, w_aluSrcA, w_aluOp, w_wbSel;
    logic       w_aluSrcB, w_regWe, w_illegal, w_retire;

    // Output and next-state decode. Outputs follow the state register and
    // the latched opcode; only the FETCH/MEM_ACC completion strobes look at
    // mem_ready. Everything is forced low while rst is high so an
    // in-flight memory request drops in the same cycle reset appears.
    always_comb begin
        w_nextState = r_state;
        w_memReq    = 1'b0;
        w_memWe     = 1'b0;
        w_iord      = 1'b0;
        w_irWe      = 1'b0;
        w_pcWe      = 1'b0;
        w_pcSrc     = 2'd0;
        w_aluSrcA   = 2'd0;
        w_aluSrcB   = 1'b0;
        w_aluOp     = 2'd0;
        w_regWe     = 1'b0;
        w_wbSel     = 2'd0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    w_memReq = 1'b1;
                    if (bus.mem_ready) begin
                        w_irWe      = 1'b1;
                        w_pcWe      = 1'b1;
                        w_nextState = DECODE;
                    end
                end
                DECODE: begin
                    case (bus.opcode)
                        OP_LOAD, OP_STORE:                     w_nextState = MEM_ADDR;
                        OP_RTYPE, OP_IALU, OP_LUI, OP_AUIPC:   w_nextState = EXEC;
                        OP_BRANCH:                             w_nextState = BRANCH;
                        OP_JAL, OP_JALR:                       w_nextState = JUMP;
                        OP_FENCE: begin
                            w_retire    = 1'b1;
                            w_nextState = FETCH;
                        end
                        default: begin
                            w_illegal   = 1'b1;
                            w_nextState = FETCH;
                        end
                    endcase
                end
                EXEC: begin
                    case (bus.opcode)
                        OP_RTYPE: w_aluOp = 2'd2;
                        OP_IALU: begin
                            w_aluSrcB = 1'b1;
                            w_aluOp   = 2'd2;
                        end
                        OP_LUI: begin
                            w_aluSrcA = 2'd2;
                            w_aluSrcB = 1'b1;
                        end
                        OP_AUIPC: begin
                            w_aluSrcA = 2'd1;
                            w_aluSrcB = 1'b1;
                        end
                        default: ;
                    endcase
                    w_nextState = ALU_WB;
                end
                ALU_WB: begin
                    w_regWe     = 1'b1;
                    w_retire    = 1'b1;
                    w_nextState = FETCH;
                end
                MEM_ADDR: begin
                    w_aluSrcB   = 1'b1;
                    w_nextState = MEM_ACC;
                end
                MEM_ACC: begin
                    w_memReq = 1'b1;
                    w_iord   = 1'b1;
                    w_memWe  = (bus.opcode == OP_STORE);
                    if (bus.mem_ready) begin
                        // Stores finish here; loads still need a write-back cycle.
                        if (bus.opcode == OP_STORE) begin
                            w_retire    = 1'b1;
                            w_nextState = FETCH;
                        end else begin
                            w_nextState = LOAD_WB;
                        end
                    end
                end
                LOAD_WB: begin
                    w_regWe     = 1'b1;
                    w_wbSel     = 2'd1;
                    w_retire    = 1'b1;
                    w_nextState = FETCH;
                end
                BRANCH: begin
                    w_aluOp = 2'd1;
                    if (bus.branch_taken) begin
                        w_pcWe  = 1'b1;
                        w_pcSrc = 2'd1;
                    end
                    w_retire    = 1'b1;
                    w_nextState = FETCH;
                end
                JUMP: begin
                    w_aluSrcB   = 1'b1;
                    w_regWe     = 1'b1;
                    w_wbSel     = 2'd2;
                    w_pcWe      = 1'b1;
                    w_pcSrc     = (bus.opcode == OP_JALR) ? 2'd2 : 2'd1;
                    w_retire    = 1'b1;
                    w_nextState = FETCH;
                end
                // Encodings 9-15 can only be reached by an upset; recover quietly.
                default: w_nextState = FETCH;
            endcase
        end
    end

    // State register and retired-instruction counter. The counter simply
    // wraps at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_retire) begin
                r_instret <= r_instret + COUNT_W'(1);
            end
        end
    end

    assign bus.mem_req   = w_memReq;
    assign bus.mem_we    = w_memWe;
    assign bus.iord      = w_iord;
    assign bus.ir_we     = w_irWe;
    assign bus.pc_we     = w_pcWe;
    assign bus.pc_src    = w_pcSrc;
    assign bus.alu_src_a = w_aluSrcA;
    assign bus.alu_src_b = w_aluSrcB;
    assign bus.alu_op    = w_aluOp;
    assign bus.reg_we    = w_regWe;
    assign bus.wb_sel    = w_wbSel;
    assign bus.illegal   = w_illegal;
    assign bus.retire    = w_retire;
    assign bus.instret   = rst ? '0 : r_instret;
    assign bus.state_o   = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed and randomized bench for multicycle_ctrl with a 4-bit instret so
// the wrap is exercised. Each instruction's expected cycle-by-cycle output
// trace is built from its instruction class and the memory wait counts.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       iord;
        logic       irWe;
        logic       pcWe;
        logic [1:0] pcSrc;
        logic [1:0] aluSrcA;
        logic       aluSrcB;
        logic [1:0] aluOp;
        logic       regWe;
        logic [1:0] wbSel;
        logic       illegal;
        logic       retire;
        logic [3:0] st;
    } outs_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   modelCount = 0;

    logic [6:0] legalOps [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111,
                                  7'b1100111, 7'b0001111};

    multicycle_ctrl_if #(.COUNT_W(CW)) bus ();

    multicycle_ctrl #(.COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Inputs change just after the falling edge and are settled #1 later,
    // well away from the rising edge that moves the FSM.
    task automatic applyStimulus(input logic r, input logic [6:0] op,
                                 input logic rdy, input logic tk);
        @(negedge clk);
        rst              = r;
        bus.opcode       = op;
        bus.mem_ready    = rdy;
        bus.branch_taken = tk;
        #1;
    endtask

    // Compares the whole control vector and the retire counter, then
    // advances the counter model if this cycle retires.
    task automatic checkOutput(input string tag, input outs_t exp);
        outs_t act;
        act.memReq  = bus.mem_req;
        act.memWe   = bus.mem_we;
        act.iord    = bus.iord;
        act.irWe    = bus.ir_we;
        act.pcWe    = bus.pc_we;
        act.pcSrc   = bus.pc_src;
        act.aluSrcA = bus.alu_src_a;
        act.aluSrcB = bus.alu_src_b;
        act.aluOp   = bus.alu_op;
        act.regWe   = bus.reg_we;
        act.wbSel   = bus.wb_sel;
        act.illegal = bus.illegal;
        act.retire  = bus.retire;
        act.st      = bus.state_o;
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("[TB] FAIL %s ctrl: observed=%h expected=%h", tag, act, exp);
        end
        checks++;
        assert (bus.instret === CW'(modelCount)) else begin
            errors++;
            $error("[TB] FAIL %s instret: observed=%0d expected=%0d", tag, bus.instret, modelCount);
        end
        if (exp.retire) modelCount = (modelCount + 1) % (1 << CW);
    endtask

    task automatic cycle(input string tag, input logic [6:0] op, input logic rdy,
                         input logic tk, input outs_t exp);
        applyStimulus(1'b0, op, rdy, tk);
        checkOutput(tag, exp);
    endtask

    // Reference for one instruction: fetch with fWait stalls, decode, then the
    // class-specific cycles, with mWait stalls on the data access.
    task automatic runInstr(input logic [6:0] op, input int fWait,
                            input int mWait, input logic tk);
        outs_t e;
        bit isLoad, isStore, isAlu, isBr, isJmp, isFence;
        isLoad  = (op == 7'b0000011);
        isStore = (op == 7'b0100011);
        isAlu   = (op == 7'b0110011) || (op == 7'b0010011) ||
                  (op == 7'b0110111) || (op == 7'b0010111);
        isBr    = (op == 7'b1100011);
        isJmp   = (op == 7'b1101111) || (op == 7'b1100111);
        isFence = (op == 7'b0001111);

        for (int i = 0; i < fWait; i++) begin
            e = '0; e.memReq = 1'b1;
            cycle("fetch_wait", 7'($urandom), 1'b0, 1'($urandom), e);
        end
        e = '0; e.memReq = 1'b1; e.irWe = 1'b1; e.pcWe = 1'b1;
        cycle("fetch_ready", 7'($urandom), 1'b1, 1'($urandom), e);

        e = '0; e.st = 4'd1;
        e.retire  = isFence;
        e.illegal = !(isLoad || isStore || isAlu || isBr || isJmp || isFence);
        cycle("decode", op, 1'($urandom), 1'($urandom), e);

        if (isAlu) begin
            e = '0; e.st = 4'd2;
            case (op)
                7'b0110011: e.aluOp = 2'd2;
                7'b0010011: begin e.aluSrcB = 1'b1; e.aluOp = 2'd2; end
                7'b0110111: begin e.aluSrcA = 2'd2; e.aluSrcB = 1'b1; end
                default:    begin e.aluSrcA = 2'd1; e.aluSrcB = 1'b1; end
            endcase
            cycle("exec", op, 1'($urandom), 1'($urandom), e);
            e = '0; e.st = 4'd3; e.regWe = 1'b1; e.retire = 1'b1;
            cycle("alu_wb", op, 1'($urandom), 1'($urandom), e);
        end else if (isLoad || isStore) begin
            e = '0; e.st = 4'd4; e.aluSrcB = 1'b1;
            cycle("mem_addr", op, 1'($urandom), 1'($urandom), e);
            for (int i = 0; i < mWait; i++) begin
                e = '0; e.st = 4'd5; e.memReq = 1'b1; e.iord = 1'b1; e.memWe = isStore;
                cycle("mem_wait", op, 1'b0, 1'($urandom), e);
            end
            e = '0; e.st = 4'd5; e.memReq = 1'b1; e.iord = 1'b1; e.memWe = isStore;
            e.retire = isStore;
            cycle("mem_ready", op, 1'b1, 1'($urandom), e);
            if (isLoad) begin
                e = '0; e.st = 4'd6; e.regWe = 1'b1; e.wbSel = 2'd1; e.retire = 1'b1;
                cycle("load_wb", op, 1'($urandom), 1'($urandom), e);
            end
        end else if (isBr) begin
            e = '0; e.st = 4'd7; e.aluOp = 2'd1; e.retire = 1'b1;
            e.pcWe = tk; e.pcSrc = tk ? 2'd1 : 2'd0;
            cycle(tk ? "branch_taken" : "branch_not_taken", op, 1'($urandom), tk, e);
        end else if (isJmp) begin
            e = '0; e.st = 4'd8; e.aluSrcB = 1'b1; e.regWe = 1'b1; e.wbSel = 2'd2;
            e.pcWe = 1'b1; e.pcSrc = (op == 7'b1100111) ? 2'd2 : 2'd1; e.retire = 1'b1;
            cycle("jump", op, 1'($urandom), 1'($urandom), e);
        end
    endtask

    // Directed sequence followed by randomized instruction streams.
    initial begin
        outs_t z;
        logic [6:0] op;
        z = '0;
        rst = 1'b1;
        bus.opcode = '0;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;

        modelCount = 0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 7'($urandom), 1'b1, 1'($urandom));
            checkOutput("reset", z);
        end

        runInstr(7'b0110011, 3, 0, 1'b0);
        runInstr(7'b0000011, 0, 2, 1'b0);
        runInstr(7'b0100011, 0, 0, 1'b0);
        runInstr(7'b1100011, 0, 0, 1'b1);
        runInstr(7'b1100011, 1, 0, 1'b0);
        runInstr(7'b1100111, 0, 0, 1'b0);
        runInstr(7'b1111111, 0, 0, 1'b0);
        runInstr(7'b0001111, 0, 0, 1'b0);
        runInstr(7'b1101111, 0, 0, 1'b0);
        runInstr(7'b0110111, 0, 0, 1'b0);
        runInstr(7'b0010111, 0, 0, 1'b0);
        runInstr(7'b0010011, 1, 0, 1'b0);

        // Reset arriving while a fetch is being granted must squash it.
        z = '0; z.memReq = 1'b1;
        cycle("fetch_before_reset", 7'($urandom), 1'b0, 1'b0, z);
        z = '0;
        modelCount = 0;
        applyStimulus(1'b1, 7'($urandom), 1'b1, 1'($urandom));
        checkOutput("reset_midreq", z);

        // Seventeen retirements on a 4-bit counter land on 1.
        for (int i = 0; i < 17; i++) begin
            runInstr(legalOps[$urandom_range(9, 0)], $urandom_range(2, 0),
                     $urandom_range(2, 0), 1'($urandom));
        end
        applyStimulus(1'b0, 7'($urandom), 1'b0, 1'b0);
        checks++;
        assert (bus.instret === 4'd1) else begin
            errors++;
            $error("[TB] FAIL wrap17: observed=%0d expected=1", bus.instret);
        end
        z = '0; z.memReq = 1'b1;
        checkOutput("fetch_after_wrap", z);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                op = 7'($urandom);
                foreach (legalOps[k]) if (legalOps[k] == op) op = 7'b1111111;
            end else begin
                op = legalOps[$urandom_range(9, 0)];
            end
            runInstr(op, $urandom_range(2, 0), $urandom_range(2, 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
